core_inst_sequencer: RTL and testbench
======================================

Name: core_inst_sequencer

Overview:
Hardware sequencer that drives the core's 34-bit instruction bus, replacing bench-driven sequencing. For each of len_kij kernel positions it runs these phases in order: weight fetch xmem->L0, weight load into PEs, activation fetch xmem->L0, execute, then OFIFO drain into pmem. It sits between a host start/done handshake and the core's inst input, and observes ofifo_valid.

Parameters:
col, 8, PE columns; weight rows per kij = col (mode 0) or 2*col (mode 1)
len_nij, 64, activation vectors per kij in mode 0; mode 1 uses len_nij/4
len_kij, 9, kernel positions per run
w_base, 11'd1024, xmem address of first weight row
a_base, 11'd0, xmem address of first activation row
gap_cycles, 10, idle cycles after weight load and after execute
ofifo_timeout, 255, maximum cycles to wait for ofifo_valid

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low; clears all state immediately
start  in  1  one-cycle pulse; begins a run when idle
mode  in  1  0=4b/4b, 1=2b/4b; sampled only on an accepted start
pmem_base  in  11  first pmem write address; sampled on an accepted start
ofifo_valid  in  1  core OFIFO has data
inst  out  34  registered instruction bus to core
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when a run completes or aborts
err  out  1  sticky OFIFO timeout flag; cleared by the next accepted start
kij_idx  out  4  current kernel position, 0..len_kij-1

Behaviour:
- inst bit map: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
- Idle value of inst is 34'h1800C0000: both CENs and WENs high, all other bits 0. acc, ififo_wr and ififo_rd are always 0. WEN_xmem is always 1.
- Reset values: inst=34'h1800C0000, busy=0, done=0, err=0, kij_idx=0, state=IDLE, all counters 0.
- Reset asserted mid-run returns to IDLE within the same cycle. No partial-phase completion is attempted.
- Derived values: N = mode ? len_nij/4 : len_nij. R = mode ? 2*col : col.
- The xmem read has 1-cycle latency, so l0_wr and pmem write strobes lag the address by one cycle.
- FSM, with cycle counts per state:
  - IDLE: a start pulse sets busy=1, clears err, sets kij_idx=0 and pmem_ptr=pmem_base, then goes to W_FETCH. A start while busy is ignored.
  - W_FETCH, R+1 cycles: cycle t<R drives CEN_xmem=0, A_xmem=w_base+t. l0_wr=1 on cycles 1..R.
  - W_LOAD, 2R cycles: l0_rd=1, load=1.
  - W_GAP: gap_cycles cycles of idle inst.
  - A_FETCH, N+1 cycles: cycle t<N drives CEN_xmem=0, A_xmem=a_base+t. l0_wr=1 on cycles 1..N.
  - EXEC, N cycles: l0_rd=1, execute=1.
  - E_GAP: gap_cycles cycles of idle inst.
  - WAIT_OF: wait for ofifo_valid. If it does not arrive within ofifo_timeout cycles, set err=1, pulse done, clear busy, go to IDLE.
  - DRAIN, N+1 cycles: ofifo_rd=1 on cycles 0..N-1. CEN_pmem=0, WEN_pmem=0, A_pmem=pmem_ptr on cycles 1..N, with pmem_ptr incrementing after each write.
  - NEXT, 1 cycle: if kij_idx==len_kij-1, pulse done, clear busy and go to IDLE. Otherwise increment kij_idx and go to W_FETCH.
- pmem_ptr is not reset between kij, so kij k writes addresses pmem_base+k*N .. pmem_base+k*N+N-1. It wraps modulo 2^11.
- Phase counters count in the state's own width and are cleared on every state entry.
- Mode-0 cycles per kij, excluding WAIT_OF: 9+16+10+65+64+10+65+1 = 240.

Test Plan:
- Reset idle: hold reset=0 for 3 cycles -> inst=34'h1800C0000, busy=0, done=0, kij_idx=0. Release with no start -> inst unchanged for 50 cycles.
- Mode 0 single kij (len_kij=1), ofifo_valid tied 1: start -> W_FETCH issues A_xmem 1024..1031 and l0_wr is high 8 cycles lagging by one. W_LOAD has 16 load cycles. A_FETCH issues A_xmem 0..63. EXEC has 64 execute cycles. DRAIN writes pmem 0..63. done pulses exactly 240 cycles after the cycle following start.
- Mode 1, len_kij=9, pmem_base=100: W_FETCH issues 16 addresses 1024..1039, W_LOAD is 32 cycles, N=16. The final kij writes pmem 228..243. kij_idx steps 0..8. One done pulse.
- OFIFO timeout: ofifo_valid held 0 -> after E_GAP plus 255 cycles, err=1, done pulses, busy=0, inst idle. The next start clears err.
- Reset mid-EXEC (reset=0 during execute) -> inst=34'h1800C0000 in the same cycle, busy=0. A subsequent start restarts from kij_idx=0.
- Start pulse during busy and mode toggled mid-run -> ignored. The phase lengths of the running mode are unchanged.

Source files
------------

// File: rtl/core_inst_sequencer_if.sv
// Host handshake and core instruction-bus bundle for core_inst_sequencer.
// The host is the master; the sequencer is the slave.
interface core_inst_sequencer_if;
  logic        start;
  logic        mode;
  logic [10:0] pmem_base;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  kij_idx;

  modport master (
    output start, mode, pmem_base, ofifo_valid,
    input  inst, busy, done, err, kij_idx
  );

  modport slave (
    input  start, mode, pmem_base, ofifo_valid,
    output inst, busy, done, err, kij_idx
  );
endinterface

// File: rtl/core_inst_sequencer.sv
// Drives the core instruction bus through weight fetch/load, activation fetch,
// execute and OFIFO drain for every kernel position of a run.
module core_inst_sequencer #(
  parameter int unsigned col           = 8,
  parameter int unsigned len_nij       = 64,
  parameter int unsigned len_kij       = 9,
  parameter logic [10:0] w_base        = 11'd1024,
  parameter logic [10:0] a_base        = 11'd0,
  parameter int unsigned gap_cycles    = 10,
  parameter int unsigned ofifo_timeout = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  core_inst_sequencer_if.slave bus
);

  localparam logic [33:0] inst_idle = 34'h1800C0000;

  localparam int unsigned b_cen_pmem = 32;
  localparam int unsigned b_wen_pmem = 31;
  localparam int unsigned b_cen_xmem = 19;
  localparam int unsigned b_ofifo_rd = 6;
  localparam int unsigned b_l0_rd    = 3;
  localparam int unsigned b_l0_wr    = 2;
  localparam int unsigned b_execute  = 1;
  localparam int unsigned b_load     = 0;

  // Counter must hold the longest phase: timeout, N+1, 2R (up to 4*col) or gap.
  localparam int unsigned max_a   = (ofifo_timeout > len_nij + 1) ? ofifo_timeout : len_nij + 1;
  localparam int unsigned max_b   = (4 * col > gap_cycles) ? 4 * col : gap_cycles;
  localparam int unsigned max_cnt = (max_a > max_b) ? max_a : max_b;
  localparam int unsigned cnt_w   = $clog2(max_cnt + 1);

  localparam logic [3:0] st_idle    = 4'd0;
  localparam logic [3:0] st_w_fetch = 4'd1;
  localparam logic [3:0] st_w_load  = 4'd2;
  localparam logic [3:0] st_w_gap   = 4'd3;
  localparam logic [3:0] st_a_fetch = 4'd4;
  localparam logic [3:0] st_exec    = 4'd5;
  localparam logic [3:0] st_e_gap   = 4'd6;
  localparam logic [3:0] st_wait_of = 4'd7;
  localparam logic [3:0] st_drain   = 4'd8;
  localparam logic [3:0] st_next    = 4'd9;

  logic [3:0]       state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [10:0]      pmem_ptr_q, pmem_ptr_d;
  logic [3:0]       kij_q, kij_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [33:0]      inst_q, inst_d;
  logic [cnt_w-1:0] n_q, r_q, n_d, r_d;

  assign n_q = mode_q ? cnt_w'(len_nij / 4) : cnt_w'(len_nij);
  assign r_q = mode_q ? cnt_w'(2 * col)     : cnt_w'(col);
  assign n_d = mode_d ? cnt_w'(len_nij / 4) : cnt_w'(len_nij);
  assign r_d = mode_d ? cnt_w'(2 * col)     : cnt_w'(col);

  // Phase sequencing; the counter restarts at zero on every state entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + cnt_w'(1);
    mode_d     = mode_q;
    pmem_ptr_d = pmem_ptr_q;
    kij_d      = kij_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    case (state_q)
      st_idle: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d    = st_w_fetch;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          kij_d      = 4'd0;
          mode_d     = bus.mode;
          pmem_ptr_d = bus.pmem_base;
        end
      end
      st_w_fetch: if (cnt_q == r_q) begin
        state_d = st_w_load;
        cnt_d   = '0;
      end
      st_w_load: if (cnt_q == r_q + r_q - cnt_w'(1)) begin
        state_d = st_w_gap;
        cnt_d   = '0;
      end
      st_w_gap: if (cnt_q == cnt_w'(gap_cycles - 1)) begin
        state_d = st_a_fetch;
        cnt_d   = '0;
      end
      st_a_fetch: if (cnt_q == n_q) begin
        state_d = st_exec;
        cnt_d   = '0;
      end
      st_exec: if (cnt_q == n_q - cnt_w'(1)) begin
        state_d = st_e_gap;
        cnt_d   = '0;
      end
      st_e_gap: if (cnt_q == cnt_w'(gap_cycles - 1)) begin
        state_d = bus.ofifo_valid ? st_drain : st_wait_of;
        cnt_d   = '0;
      end
      st_wait_of: begin
        if (bus.ofifo_valid) begin
          state_d = st_drain;
          cnt_d   = '0;
        end else if (cnt_q == cnt_w'(ofifo_timeout - 1)) begin
          state_d = st_idle;
          cnt_d   = '0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      st_drain: if (cnt_q == n_q) begin
        state_d = st_next;
        cnt_d   = '0;
      end
      st_next: begin
        cnt_d = '0;
        if (kij_q == 4'(len_kij - 1)) begin
          state_d = st_idle;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = st_w_fetch;
          kij_d   = kij_q + 4'd1;
        end
      end
      default: begin
        state_d = st_idle;
        cnt_d   = '0;
      end
    endcase
    // Pointer advances as each pmem write is scheduled.
    if (state_d == st_drain && cnt_d != '0) pmem_ptr_d = pmem_ptr_q + 11'd1;
  end

  // Instruction for the upcoming cycle, decoded from the next state and count.
  always_comb begin
    inst_d = inst_idle;
    case (state_d)
      st_w_fetch: begin
        if (cnt_d < r_d) begin
          inst_d[b_cen_xmem] = 1'b0;
          inst_d[17:7]       = w_base + 11'(cnt_d);
        end
        inst_d[b_l0_wr] = (cnt_d != '0);
      end
      st_w_load: begin
        inst_d[b_l0_rd] = 1'b1;
        inst_d[b_load]  = 1'b1;
      end
      st_a_fetch: begin
        if (cnt_d < n_d) begin
          inst_d[b_cen_xmem] = 1'b0;
          inst_d[17:7]       = a_base + 11'(cnt_d);
        end
        inst_d[b_l0_wr] = (cnt_d != '0);
      end
      st_exec: begin
        inst_d[b_l0_rd]   = 1'b1;
        inst_d[b_execute] = 1'b1;
      end
      st_drain: begin
        inst_d[b_ofifo_rd] = (cnt_d < n_d);
        if (cnt_d != '0) begin
          inst_d[b_cen_pmem] = 1'b0;
          inst_d[b_wen_pmem] = 1'b0;
          inst_d[30:20]      = pmem_ptr_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= st_idle;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      pmem_ptr_q <= 11'd0;
      kij_q      <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      inst_q     <= inst_idle;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      pmem_ptr_q <= pmem_ptr_d;
      kij_q      <= kij_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      inst_q     <= inst_d;
    end
  end

  assign bus.inst    = inst_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.kij_idx = kij_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Directed bench for core_inst_sequencer: one single-kij instance and one nine-kij instance.
module tb_core_inst_sequencer;

  localparam logic [33:0] IDLE = 34'h1800C0000;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   t0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  core_inst_sequencer_if if0 ();
  core_inst_sequencer_if if9 ();

  core_inst_sequencer #(.len_kij(1)) u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  core_inst_sequencer #(.len_kij(9)) u_dut9 (.clk(clk), .reset(reset), .bus(if9.slave));

  function automatic logic [33:0] g_inst(input bit sel);
    return sel ? if9.inst : if0.inst;
  endfunction
  function automatic logic g_busy(input bit sel);
    return sel ? if9.busy : if0.busy;
  endfunction
  function automatic logic g_done(input bit sel);
    return sel ? if9.done : if0.done;
  endfunction
  function automatic logic g_err(input bit sel);
    return sel ? if9.err : if0.err;
  endfunction
  function automatic logic [3:0] g_kij(input bit sel);
    return sel ? if9.kij_idx : if0.kij_idx;
  endfunction

  // Expected instruction word from individual field values.
  function automatic logic [33:0] ei(input logic xrd, input logic [10:0] ax, input logic l0wr,
                                     input logic l0rd, input logic ex, input logic ld,
                                     input logic ofrd, input logic pwr, input logic [10:0] ap);
    logic [33:0] v;
    v = IDLE;
    if (xrd) begin
      v[19]   = 1'b0;
      v[17:7] = ax;
    end
    v[2] = l0wr;
    v[3] = l0rd;
    v[1] = ex;
    v[0] = ld;
    v[6] = ofrd;
    if (pwr) begin
      v[32]    = 1'b0;
      v[31]    = 1'b0;
      v[30:20] = ap;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) if9.start = v; else if0.start = v;
  endtask
  task automatic set_mode(input bit sel, input logic v);
    if (sel) if9.mode = v; else if0.mode = v;
  endtask

  // Check one running cycle, then advance to the next.
  task automatic step(input bit sel, input string tag, input logic [33:0] exp, input logic [3:0] kij);
    chk({tag, ".inst"}, g_inst(sel), exp);
    chk({tag, ".busy"}, 34'(g_busy(sel)), 34'd1);
    chk({tag, ".done"}, 34'(g_done(sel)), 34'd0);
    chk({tag, ".kij"},  34'(g_kij(sel)), 34'(kij));
    tick();
  endtask

  task automatic do_start(input bit sel, input logic m, input logic [10:0] pb);
    if (sel) begin
      if9.mode = m; if9.pmem_base = pb;
    end else begin
      if0.mode = m; if0.pmem_base = pb;
    end
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
  endtask

  // W_FETCH through E_GAP; exec_stop < n returns inside EXEC without stepping that cycle.
  task automatic front(input bit sel, input int r, input int n, input logic [3:0] k,
                       input bit disturb, input int exec_stop);
    for (int t = 0; t <= r; t++)
      step(sel, "wfetch", ei(t < r, (t < r) ? 11'(1024 + t) : 11'd0, t >= 1,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0), k);
    for (int t = 0; t < 2 * r; t++) begin
      if (disturb && t == 3) begin
        set_start(sel, 1'b1);
        set_mode(sel, 1'b1);
      end
      if (disturb && t == 4) set_start(sel, 1'b0);
      step(sel, "wload", ei(1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0), k);
    end
    for (int t = 0; t < 10; t++) step(sel, "wgap", IDLE, k);
    for (int t = 0; t <= n; t++)
      step(sel, "afetch", ei(t < n, (t < n) ? 11'(t) : 11'd0, t >= 1,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0), k);
    for (int t = 0; t < n; t++) begin
      if (t == exec_stop) return;
      step(sel, "exec", ei(1'b0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0), k);
    end
    for (int t = 0; t < 10; t++) step(sel, "egap", IDLE, k);
  endtask

  // DRAIN and NEXT.
  task automatic back(input bit sel, input int n, input logic [10:0] ptr, input logic [3:0] k);
    for (int t = 0; t <= n; t++)
      step(sel, "drain", ei(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, t < n, t >= 1,
                            11'(ptr + t - 1)), k);
    step(sel, "next", IDLE, k);
  endtask

  task automatic fin(input bit sel, input logic exp_err);
    chk("fin.done", 34'(g_done(sel)), 34'd1);
    chk("fin.busy", 34'(g_busy(sel)), 34'd0);
    chk("fin.err",  34'(g_err(sel)),  34'(exp_err));
    chk("fin.inst", g_inst(sel), IDLE);
    tick();
    chk("fin.done_low", 34'(g_done(sel)), 34'd0);
    chk("fin.err_hold", 34'(g_err(sel)),  34'(exp_err));
  endtask

  initial begin
    reset = 1'b0;
    if0.start = 1'b0; if0.mode = 1'b0; if0.pmem_base = 11'd0; if0.ofifo_valid = 1'b0;
    if9.start = 1'b0; if9.mode = 1'b0; if9.pmem_base = 11'd0; if9.ofifo_valid = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.inst0", if0.inst, IDLE);
      chk("rst.busy0", 34'(if0.busy), 34'd0);
      chk("rst.done0", 34'(if0.done), 34'd0);
      chk("rst.err0",  34'(if0.err),  34'd0);
      chk("rst.kij0",  34'(if0.kij_idx), 34'd0);
      chk("rst.inst9", if9.inst, IDLE);
      chk("rst.busy9", 34'(if9.busy), 34'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle.inst", if0.inst, IDLE);
      chk("idle.busy", 34'(if0.busy), 34'd0);
    end
    chk("idle.inst9", if9.inst, IDLE);

    // Mode 0, single kij, OFIFO always ready
    if0.ofifo_valid = 1'b1;
    do_start(1'b0, 1'b0, 11'd0);
    t0 = cyc;
    front(1'b0, 8, 64, 4'd0, 1'b0, 64);
    back(1'b0, 64, 11'd0, 4'd0);
    chk("m0.latency", 34'(cyc - t0), 34'd240);
    fin(1'b0, 1'b0);

    // Mode 0 again with start/mode disturbed mid-run; pmem addresses wrap past 2047
    do_start(1'b0, 1'b0, 11'd2000);
    front(1'b0, 8, 64, 4'd0, 1'b1, 64);
    back(1'b0, 64, 11'd2000, 4'd0);
    fin(1'b0, 1'b0);
    if0.mode = 1'b0;

    // Mode 1, nine kij, pmem_base 100
    if9.ofifo_valid = 1'b1;
    do_start(1'b1, 1'b1, 11'd100);
    for (int k = 0; k < 9; k++) begin
      front(1'b1, 16, 16, 4'(k), 1'b0, 16);
      back(1'b1, 16, 11'(100 + 16 * k), 4'(k));
    end
    fin(1'b1, 1'b0);

    // OFIFO timeout
    if0.ofifo_valid = 1'b0;
    do_start(1'b0, 1'b0, 11'd0);
    front(1'b0, 8, 64, 4'd0, 1'b0, 64);
    for (int t = 0; t < 255; t++) step(1'b0, "waitof", IDLE, 4'd0);
    fin(1'b0, 1'b1);

    // Next start clears err
    if0.ofifo_valid = 1'b1;
    do_start(1'b0, 1'b0, 11'd0);
    chk("restart.err", 34'(if0.err), 34'd0);
    front(1'b0, 8, 64, 4'd0, 1'b0, 64);
    back(1'b0, 64, 11'd0, 4'd0);
    fin(1'b0, 1'b0);

    // Reset during EXEC of the second kij
    do_start(1'b1, 1'b1, 11'd100);
    front(1'b1, 16, 16, 4'd0, 1'b0, 16);
    back(1'b1, 16, 11'd100, 4'd0);
    front(1'b1, 16, 16, 4'd1, 1'b0, 5);
    chk("midrst.pre_inst", if9.inst, ei(1'b0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0));
    reset = 1'b0;
    #1;
    chk("midrst.inst", if9.inst, IDLE);
    chk("midrst.busy", 34'(if9.busy), 34'd0);
    chk("midrst.kij",  34'(if9.kij_idx), 34'd0);
    chk("midrst.done", 34'(if9.done), 34'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("postrst.inst", if9.inst, IDLE);
    do_start(1'b1, 1'b0, 11'd0);
    front(1'b1, 8, 64, 4'd0, 1'b0, 64);
    back(1'b1, 64, 11'd0, 4'd0);
    chk("postrst.kij1", 34'(if9.kij_idx), 34'd1);
    chk("postrst.busy", 34'(if9.busy), 34'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
